// File: rtl/counter_pkg.sv
// Shared counter package: wrap/saturate mode constants, a bound clamp helper,
// and the COUNTER_PARAM_CHECK elaboration guard used across the counter family.
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// Expands to a named generate block that raises an elaboration error when cond is false.
`define COUNTER_PARAM_CHECK(cond, label) \
  if (!(cond)) begin : label \
    $error("counter parameter check failed"); \
  end

package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

`endif

// File: rtl/updown_mod_counter_edge_pend.sv
// Rising-edge detector with a pending flag; the flag survives until an enable
// cycle consumes it, so one button press yields exactly one step.
module edge_pend (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_consume,
  input  logic i_clear,
  output logic o_pend
);
  logic r_prev;
  logic r_pend;
  logic w_edge;

  assign w_edge = i_req & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_req;
      // A fresh edge in the consuming cycle re-arms the flag.
      if (i_clear) r_pend <= 1'b0;
      else         r_pend <= w_edge | (r_pend & ~i_consume);
    end
  end

  assign o_pend = r_pend;
endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable bounds, wrap/saturate, clamped load
// and registered carry/borrow pulses. Define UPDN_EDGE_STEP_EN for edge-pressed steps.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN      = 0,
  parameter int MAX      = 10,
  parameter int RST_VAL  = 0,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow,
  output logic             at_min,
  output logic             at_max
);
  `COUNTER_PARAM_CHECK(WIDTH >= 1 && WIDTH <= 30, g_chk_width)
  `COUNTER_PARAM_CHECK(MIN >= 0 && MIN < MAX, g_chk_order)
  `COUNTER_PARAM_CHECK(MAX <= (1 << WIDTH) - 1, g_chk_fit)
  `COUNTER_PARAM_CHECK(RST_VAL >= MIN && RST_VAL <= MAX, g_chk_rst)
  `COUNTER_PARAM_CHECK(SATURATE == MODE_WRAP || SATURATE == MODE_SAT, g_chk_mode)

  // One extra bit so MAX = 2**WIDTH-1 cannot overflow silently.
  localparam logic [WIDTH:0] L_MIN = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0] L_MAX = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] L_ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_borrow;
  logic             w_step_up;
  logic             w_step_dn;
  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_nxt;
  logic             w_carry_nxt;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_load;
  logic             w_unused_msb;

`ifdef UPDN_EDGE_STEP_EN
  logic w_pend_up;
  logic w_pend_dn;

  edge_pend u_pend_up (
    .clk       (clk),
    .rst       (rst),
    .i_req     (up),
    .i_consume (EN),
    .i_clear   (load),
    .o_pend    (w_pend_up)
  );

  edge_pend u_pend_dn (
    .clk       (clk),
    .rst       (rst),
    .i_req     (down),
    .i_consume (EN),
    .i_clear   (load),
    .o_pend    (w_pend_dn)
  );

  assign w_step_up = EN & w_pend_up & ~w_pend_dn;
  assign w_step_dn = EN & w_pend_dn & ~w_pend_up;
`else
  assign w_step_up = EN & up & ~down;
  assign w_step_dn = EN & down & ~up;
`endif

  assign w_cur  = {1'b0, r_out};
  assign w_load = WIDTH'(clamp(int'(load_val), MIN, MAX));

  always_comb begin
    w_nxt        = w_cur;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    if (w_step_up) begin
      if (w_cur < L_MAX) begin
        w_nxt = w_cur + L_ONE;
      end else if (SATURATE == MODE_WRAP) begin
        w_nxt       = L_MIN;
        w_carry_nxt = 1'b1;
      end
    end else if (w_step_dn) begin
      if (w_cur > L_MIN) begin
        w_nxt = w_cur - L_ONE;
      end else if (SATURATE == MODE_WRAP) begin
        w_nxt        = L_MAX;
        w_borrow_nxt = 1'b1;
      end
    end
  end

  // The top bit stays zero because w_nxt is always within [MIN, MAX].
  assign w_unused_msb = w_nxt[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= WIDTH'(RST_VAL);
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else if (load) begin
      r_out    <= w_load;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_out    <= w_nxt[WIDTH-1:0];
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign out    = r_out;
  assign carry  = r_carry;
  assign borrow = r_borrow;
  assign at_min = (w_cur == L_MIN);
  assign at_max = (w_cur == L_MAX);
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo counter with programmable bounds, wrap or saturate mode, parallel load, and registered carry/borrow pulses for cascading digits. It is the general-purpose successor of the fixed-range 4-bit digit counter, used for time/date fields and setpoint digits, and is chained via `carry`/`borrow` into the next digit's `EN`.

## Interface
- `WIDTH`, 4, counter width in bits.
- `MIN`, 0, lowest count value.
- `MAX`, 10, highest count value.
- `RST_VAL`, 0, value loaded by reset.
- `SATURATE`, 0, 0 selects wrap at bounds, 1 selects hold at bounds.
- Legal values: `MIN < MAX <= 2**WIDTH-1` and `MIN <= RST_VAL <= MAX`. Violations are an elaboration error.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `EN`  in  1  count enable / tick qualifier.
- `up`  in  1  step-up request.
- `down`  in  1  step-down request.
- `load`  in  1  parallel load strobe, independent of `EN`.
- `load_val`  in  WIDTH  value to load, clamped to [MIN, MAX].
- `out`  out  WIDTH  registered count.
- `carry`  out  1  one-cycle pulse on wrap MAX->MIN.
- `borrow`  out  1  one-cycle pulse on wrap MIN->MAX.
- `at_min`  out  1  `out == MIN`, combinational from `out`.
- `at_max`  out  1  `out == MAX`, combinational from `out`.

## Operation
- Priority per clock edge: `rst` > `load` > step > hold.
- `rst`: `out`=RST_VAL, `carry`=0, `borrow`=0, and pending requests are cleared. `at_min`/`at_max` follow `out`.
- `load`: `out` = clamp(`load_val`) (>MAX gives MAX, <MIN gives MIN). No carry/borrow. Pending requests are cleared.
- Step occurs only when `EN`=1 and exactly one of up/down is requested. When up and down are both requested, or neither is, `out` holds.
- Up:
  - `out<MAX`: increment.
  - `out==MAX`: wrap mode sets `out`=MIN and `carry`=1; saturate mode holds, no pulse.
- Down:
  - `out>MIN`: decrement.
  - `out==MIN`: wrap mode sets `out`=MAX and `borrow`=1; saturate mode holds, no pulse.
- Arithmetic is done at WIDTH+1 bits internally, so MAX=2**WIDTH-1 never overflows silently.
- `carry`/`borrow` are 0 in every cycle not described above. They are never both 1.

## Timing
- `out` updates on the edge where the request is sampled, visible the next cycle (latency 1).
- `carry`/`borrow` are registered and asserted in the same cycle that `out` first shows the wrapped value, for exactly one cycle.
- Consecutive `EN` cycles with `up` held give one step per cycle, including repeated wraps.
- A `load` in the same cycle as a wrap step suppresses the pulse.
- A `rst` mid-sequence overrides everything on that edge.

## Configuration
- Macro `UPDN_EDGE_STEP_EN`.
- Undefined (default): `up`/`down` are level requests sampled on `EN` cycles.
- Defined:
  - `up`/`down` are rising-edge detected every `clk`, independent of `EN`.
  - An edge sets a pending flag (`pend_up`/`pend_dn`). The flag is consumed by the next `EN` cycle, giving exactly one step per press however long the button is held.
  - Both flags set at consumption: both are cleared, no step.
  - Edge-detector history resets to 0, so `up` high out of reset counts as one press.
  - A new edge in the consuming cycle re-arms the flag.

## Structure
- Shared package `counter_pkg`: `MODE_WRAP`/`MODE_SAT` constants, a clamp function, and a parameter-check macro shared with the other counters.
- One sub-module, `edge_pend`: rising-edge detector plus pending flag with `consume`/`clear` inputs. It is instantiated twice (up, down) only under `UPDN_EDGE_STEP_EN`.

## Test plan
- Reset: defaults, `rst`=1 for 2 cycles -> `out`=0, `carry`=`borrow`=0, `at_min`=1.
- Wrap up: `up`=1, `EN`=1 for 11 cycles from 0 -> `out` 1..10 then 0. `carry`=1 only in the cycle `out`=0.
- Wrap down and simultaneous requests: from 0, `down` -> `out`=10 with `borrow`=1. `up`=`down`=1 -> hold. `EN`=0 -> hold.
- Saturate: SATURATE=1, MIN=3, MAX=9 -> at 9 with `up`, `out` stays 9, no `carry`. At 3 with `down`, `out` stays 3.
- Load: `load_val`=14 -> `out`=10. `load_val`=5 with `up`, `EN` -> `out`=5 (load wins). A load during a would-be wrap gives no pulse.
- `UPDN_EDGE_STEP_EN`: hold `up` 20 cycles with `EN` every 4th cycle -> exactly one increment. Press `up` and `down` before the same `EN` -> no step.
